// File: rtl/sram_march_bist.sv
// March C- self-test initiator for a single-port synchronous SRAM with registered read data.
// Optional MBIST_ABORT_ON_FAIL_EN: stop the run on the first mismatch instead of finishing it.
module sram_march_bist #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_DEPTH = 16,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_elem,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_din,
  input  logic [WORD_WIDTH-1:0] mem_dout
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [WORD_WIDTH-1:0] D0 = '0;
  localparam logic [WORD_WIDTH-1:0] D1 = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state_reg, state_next;
  logic [2:0]            elem_reg, elem_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  phase_reg, phase_next;

  // Sequencer output for the current cycle; it reaches the SRAM pins one edge later.
  logic                  op_wr, op_rd;
  logic [WORD_WIDTH-1:0] op_data, op_exp;
  logic                  descending, last_addr, paired;

  // Read staging aligned with the SRAM pins, then the compare register aligned with mem_dout.
  logic                  rd_pend_reg;
  logic [WORD_WIDTH-1:0] rd_exp_reg;
  logic [2:0]            rd_elem_reg;
  logic                  cmp_valid_reg;
  logic [WORD_WIDTH-1:0] cmp_exp_reg;
  logic [ADDR_WIDTH-1:0] cmp_addr_reg;
  logic [2:0]            cmp_elem_reg;

  logic mismatch, set_fail, abort, bus_wr, bus_rd;

  assign mismatch = cmp_valid_reg && (mem_dout != cmp_exp_reg);
  assign set_fail = mismatch && !fail;

`ifdef MBIST_ABORT_ON_FAIL_EN
  assign abort = set_fail && ((state_reg == RUN) || (state_reg == DRAIN));
`else
  assign abort = 1'b0;
`endif

  assign bus_wr = op_wr && !abort;
  assign bus_rd = op_rd && !abort;

  always_comb begin
    state_next = state_reg;
    elem_next  = elem_reg;
    addr_next  = addr_reg;
    phase_next = phase_reg;
    op_wr      = 1'b0;
    op_rd      = 1'b0;
    op_data    = D0;
    op_exp     = D0;
    descending = (elem_reg == 3'd3) || (elem_reg == 3'd4);
    last_addr  = descending ? (addr_reg == '0) : (addr_reg == LAST_ADDR);
    paired     = (elem_reg >= 3'd1) && (elem_reg <= 3'd4);

    case (state_reg)
      IDLE: begin
        elem_next  = 3'd0;
        addr_next  = '0;
        phase_next = 1'b0;
        if (start) state_next = RUN;
      end
      RUN: begin
        if (paired && !phase_reg) begin
          op_rd      = 1'b1;
          op_exp     = ((elem_reg == 3'd2) || (elem_reg == 3'd4)) ? D1 : D0;
          phase_next = 1'b1;
        end else begin
          if (elem_reg == 3'd5) begin
            op_rd  = 1'b1;
            op_exp = D0;
          end else begin
            op_wr   = 1'b1;
            op_data = ((elem_reg == 3'd1) || (elem_reg == 3'd3)) ? D1 : D0;
          end
          phase_next = 1'b0;
          if (last_addr) begin
            if (elem_reg == 3'd5) begin
              state_next = DRAIN;
            end else begin
              elem_next = elem_reg + 3'd1;
              // E3 and E4 walk downward, so they start at the top address.
              addr_next = ((elem_reg == 3'd2) || (elem_reg == 3'd3)) ? LAST_ADDR : '0;
            end
          end else begin
            addr_next = descending ? addr_reg - ADDR_WIDTH'(1) : addr_reg + ADDR_WIDTH'(1);
          end
        end
        if (abort) state_next = DONE;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      elem_reg      <= 3'd0;
      addr_reg      <= '0;
      phase_reg     <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_elem     <= 3'd0;
      mem_we        <= 1'b1;
      mem_addr      <= '0;
      mem_din       <= '0;
      rd_pend_reg   <= 1'b0;
      rd_exp_reg    <= '0;
      rd_elem_reg   <= 3'd0;
      cmp_valid_reg <= 1'b0;
      cmp_exp_reg   <= '0;
      cmp_addr_reg  <= '0;
      cmp_elem_reg  <= 3'd0;
    end else begin
      state_reg <= state_next;
      elem_reg  <= elem_next;
      addr_reg  <= addr_next;
      phase_reg <= phase_next;

      busy <= ((state_reg == RUN) || (state_reg == DRAIN)) && !abort;
      done <= (state_reg == DONE);

      mem_we   <= !bus_wr;
      mem_addr <= (bus_wr || bus_rd) ? addr_reg : '0;
      mem_din  <= bus_wr ? op_data : D0;

      rd_pend_reg   <= bus_rd;
      rd_exp_reg    <= op_exp;
      rd_elem_reg   <= elem_reg;
      cmp_valid_reg <= rd_pend_reg;
      cmp_exp_reg   <= rd_exp_reg;
      cmp_addr_reg  <= mem_addr;
      cmp_elem_reg  <= rd_elem_reg;

      if ((state_reg == IDLE) && start) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= 3'd0;
      end else if (set_fail) begin
        fail      <= 1'b1;
        fail_addr <= cmp_addr_reg;
        fail_elem <= cmp_elem_reg;
      end
    end
  end

endmodule

// File: tb/tb_sram_march_bist.sv
// Scoreboard bench for sram_march_bist: a loop-level March C- model predicts every SRAM
// operation and the end-of-test report; a negedge monitor compares them against the DUT.
module tb_sram_march_bist;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int W  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, fail, mem_we;
  logic [AW-1:0] fail_addr, mem_addr;
  logic [2:0]    fail_elem;
  logic [W-1:0]  mem_din, mem_dout;

  always #5 clk = ~clk;

  sram_march_bist #(.ADDR_WIDTH(AW), .WORD_DEPTH(D), .WORD_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .fail(fail),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // SRAM with an optional stuck-at cell applied on read.
  logic [W-1:0] sram [D];
  logic fault_en = 1'b0;
  int   fault_addr = 0;
  int   fault_bit = 0;
  logic fault_val = 1'b0;

  function automatic logic [W-1:0] faulty(int a, logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    if (fault_en && a == fault_addr) r[fault_bit] = fault_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= faulty(int'(mem_addr), sram[mem_addr]);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; int addr; logic [W-1:0] din; } bus_t;
  typedef struct { logic f; int addr; int elem; int done_cyc; } res_t;
  bus_t bus_q[$];
  res_t res_q[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: element table walked with plain loops over a word array.
  task automatic model_run(output logic f, output int fa, output int fe);
    logic [W-1:0] m [D];
    int desc[6];
    int rd[6];
    int rv[6];
    int wr[6];
    int wv[6];
    bus_t b;
    logic [W-1:0] expv, got;
    int a;
    desc = '{0, 0, 0, 1, 1, 0};
    rd   = '{0, 1, 1, 1, 1, 1};
    rv   = '{0, 0, 1, 0, 1, 0};
    wr   = '{1, 1, 1, 1, 1, 0};
    wv   = '{0, 1, 0, 1, 0, 0};
    f = 1'b0; fa = 0; fe = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < D; i++) begin
        a = (desc[e] != 0) ? D - 1 - i : i;
        if (rd[e] != 0) begin
          b.we = 1'b1; b.addr = a; b.din = '0;
          bus_q.push_back(b);
          expv = (rv[e] != 0) ? {W{1'b1}} : {W{1'b0}};
          got  = faulty(a, m[a]);
          if (got !== expv && !f) begin f = 1'b1; fa = a; fe = e; end
        end
        if (wr[e] != 0) begin
          b.we = 1'b0; b.addr = a; b.din = (wv[e] != 0) ? {W{1'b1}} : {W{1'b0}};
          bus_q.push_back(b);
          m[a] = b.din;
        end
      end
    end
    b.we = 1'b1; b.addr = 0; b.din = '0;
    bus_q.push_back(b);
  endtask

  // Monitor: every busy cycle carries the next predicted bus operation; done carries a report.
  int   busy_cnt = 0;
  bus_t mb;
  res_t mr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) begin
        busy_cnt++;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_cycle", 32'd1, 32'd0);
        end else begin
          mb = bus_q.pop_front();
          chk("bus_op", {19'd0, mem_we, mem_addr, mem_din}, {19'd0, mb.we, mb.addr[AW-1:0], mb.din});
        end
      end else begin
        chk("idle_we", {31'd0, mem_we}, 32'd1);
      end
      if (done) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          mr = res_q.pop_front();
          chk("done_cycle", cyc, mr.done_cyc);
          chk("busy_cycles", busy_cnt, 161);
          chk("fail", {31'd0, fail}, {31'd0, mr.f});
          $display("run done: cycle=%0d fail=%0d fail_addr=%0d fail_elem=%0d", cyc, fail, fail_addr, fail_elem);
          if (mr.f) begin
            chk("fail_addr", {28'd0, fail_addr}, mr.addr);
            chk("fail_elem", {29'd0, fail_elem}, mr.elem);
          end
        end
        busy_cnt = 0;
      end else if (!busy) begin
        busy_cnt = 0;
      end
    end
  end

  task automatic wait_results(input int budget);
    int n;
    n = 0;
    while (res_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("run_timeout", res_q.size(), 0);
    chk("bus_ops_left", bus_q.size(), 0);
    res_q.delete();
    bus_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_one(input logic fen, input int fa, input int fb, input logic fv);
    logic f;
    int ea, ee;
    res_t r;
    @(negedge clk);
    fault_en = fen; fault_addr = fa; fault_bit = fb; fault_val = fv;
    model_run(f, ea, ee);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r.f = f; r.addr = ea; r.elem = ee; r.done_cyc = cyc + 162;
    res_q.push_back(r);
    wait_results(400);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic f;
    int ea, ee, t0;
    res_t r;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_fail", {31'd0, fail}, 32'd0);
    chk("rst_fail_addr", {28'd0, fail_addr}, 32'd0);
    chk("rst_fail_elem", {29'd0, fail_elem}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd1);
    chk("rst_mem_addr", {28'd0, mem_addr}, 32'd0);
    chk("rst_mem_din", {24'd0, mem_din}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_one(1'b0, 0, 0, 1'b0);   // fault-free
    run_one(1'b1, 5, 3, 1'b1);   // stuck-at-1, bit 3 of word 5
    run_one(1'b1, 12, 0, 1'b0);  // stuck-at-0, bit 0 of word 12

    // Reset pulse during E3 aborts the run with no done pulse.
    @(negedge clk);
    fault_en = 1'b0;
    model_run(f, ea, ee);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_we}, 32'd1);
    chk("abort_done", {31'd0, done}, 32'd0);
    bus_q.delete();
    repeat (200) @(negedge clk);

    run_one(1'b0, 0, 0, 1'b0);   // clean run after the abort

    // start held high: two back-to-back runs, start ignored while busy.
    @(negedge clk);
    fault_en = 1'b0;
    model_run(f, ea, ee);
    model_run(f, ea, ee);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    r.f = 1'b0; r.addr = 0; r.elem = 0;
    r.done_cyc = t0 + 162;
    res_q.push_back(r);
    r.done_cyc = t0 + 325;
    res_q.push_back(r);
    repeat (299) @(posedge clk);
    #1;
    start = 1'b0;
    wait_results(400);

    for (int k = 0; k < 6; k++) begin
      run_one(1'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
              int'($urandom_range(0, W - 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
